// File: rtl/mem_pkg.sv
// Shared definitions for the memory access path: state and channel encodings,
// default bus widths and the wait-counter width.
package mem_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CH_ROM = 2'd0,
        CH_RDR = 2'd1,
        CH_RDW = 2'd2
    } chan_t;

    // True when two or more of the three grants are asserted together.
    function automatic logic multi_grant(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter used to time memory wait states; stops at zero.
module mem_wait_counter
    import mem_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);

    // Load takes precedence over decrement; the count never wraps below zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Performs the ROM/RAM access selected by the arbiter grants: latches the
// request, holds the enable for the programmed wait states, returns read data
// and pulses a per-channel done, then waits for the grant to be released.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ROM_WAIT = 1,
    parameter int RAM_WAIT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rom_garant,
    input  logic              ram_garant_rd,
    input  logic              ram_garant_wr,
    input  logic [ADDR_W-1:0] rom_addr,
    input  logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_wdata,
    output logic              mem_rom_en,
    output logic [ADDR_W-1:0] mem_rom_addr,
    input  logic [DATA_W-1:0] mem_rom_rdata,
    output logic              mem_ram_en,
    output logic              mem_ram_we,
    output logic [ADDR_W-1:0] mem_ram_addr,
    output logic [DATA_W-1:0] mem_ram_wdata,
    input  logic [DATA_W-1:0] mem_ram_rdata,
    output logic [DATA_W-1:0] rom_rdata,
    output logic [DATA_W-1:0] ram_rdata,
    output logic              rom_done,
    output logic              ram_rd_done,
    output logic              ram_wr_done,
    output logic              busy,
    output logic              err_multi
);

    localparam logic [CNT_W-1:0] ROM_CNT = CNT_W'(ROM_WAIT);
    localparam logic [CNT_W-1:0] RAM_CNT = CNT_W'(RAM_WAIT);

    state_t             state;
    state_t             next_state;
    chan_t              chan;
    chan_t              sel_chan;
    logic               any_grant;
    logic               served_grant;
    logic               load;
    logic               dec;
    logic [CNT_W-1:0]   load_val;
    logic [CNT_W-1:0]   cnt;
    logic               zero;
    logic [ADDR_W-1:0]  rom_addr_q;
    logic [ADDR_W-1:0]  ram_addr_q;
    logic [DATA_W-1:0]  wdata_q;

    mem_wait_counter #(.W(CNT_W)) u_wait (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .dec      (dec),
        .cnt      (cnt),
        .zero     (zero)
    );

    // Priority pick among the grants and the level of the grant being served.
    always_comb begin
        any_grant    = rom_garant | ram_garant_rd | ram_garant_wr;
        sel_chan     = CH_RDW;
        served_grant = 1'b0;
        if (rom_garant) begin
            sel_chan = CH_ROM;
        end else if (ram_garant_rd) begin
            sel_chan = CH_RDR;
        end
        case (chan)
            CH_ROM:  served_grant = rom_garant;
            CH_RDR:  served_grant = ram_garant_rd;
            CH_RDW:  served_grant = ram_garant_wr;
            default: served_grant = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and wait-counter control.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        dec        = 1'b0;
        load_val   = RAM_CNT;
        case (state)
            IDLE: begin
                if (any_grant) begin
                    next_state = ACC;
                    load       = 1'b1;
                    load_val   = (sel_chan == CH_ROM) ? ROM_CNT : RAM_CNT;
                end
            end
            ACC: begin
                if (zero) begin
                    next_state = HOLD;
                end else begin
                    dec = 1'b1;
                end
            end
            HOLD: begin
                if (!served_grant) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Request latching, read-data capture, done pulses and the sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            chan        <= CH_ROM;
            rom_addr_q  <= '0;
            ram_addr_q  <= '0;
            wdata_q     <= '0;
            rom_rdata   <= '0;
            ram_rdata   <= '0;
            rom_done    <= 1'b0;
            ram_rd_done <= 1'b0;
            ram_wr_done <= 1'b0;
            err_multi   <= 1'b0;
        end else begin
            rom_done    <= 1'b0;
            ram_rd_done <= 1'b0;
            ram_wr_done <= 1'b0;
            if ((state == IDLE) && any_grant) begin
                chan <= sel_chan;
                if (sel_chan == CH_ROM) begin
                    rom_addr_q <= rom_addr;
                end else begin
                    ram_addr_q <= ram_addr;
                end
                if (sel_chan == CH_RDW) begin
                    wdata_q <= ram_wdata;
                end
                if (multi_grant(rom_garant, ram_garant_rd, ram_garant_wr)) begin
                    err_multi <= 1'b1;
                end
            end
            if ((state == ACC) && zero) begin
                case (chan)
                    CH_ROM: begin
                        rom_rdata <= mem_rom_rdata;
                        rom_done  <= 1'b1;
                    end
                    CH_RDR: begin
                        ram_rdata   <= mem_ram_rdata;
                        ram_rd_done <= 1'b1;
                    end
                    CH_RDW: begin
                        ram_wr_done <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign mem_rom_en    = (state == ACC) && (chan == CH_ROM);
    assign mem_ram_en    = (state == ACC) && (chan != CH_ROM);
    assign mem_ram_we    = (state == ACC) && (chan == CH_RDW) && zero;
    assign mem_rom_addr  = rom_addr_q;
    assign mem_ram_addr  = ram_addr_q;
    assign mem_ram_wdata = wdata_q;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios followed by
// random grant/data traffic, all compared against a timeline-based model.
module tb_mem_access_ctrl;

    localparam int ROM_W = 1;
    localparam int RAM_W = 2;

    logic       clk;
    logic       reset;
    logic       rom_garant;
    logic       ram_garant_rd;
    logic       ram_garant_wr;
    logic [7:0] rom_addr;
    logic [7:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] mem_rom_rdata;
    logic [7:0] mem_ram_rdata;
    logic       mem_rom_en;
    logic [7:0] mem_rom_addr;
    logic       mem_ram_en;
    logic       mem_ram_we;
    logic [7:0] mem_ram_addr;
    logic [7:0] mem_ram_wdata;
    logic [7:0] rom_rdata;
    logic [7:0] ram_rdata;
    logic       rom_done;
    logic       ram_rd_done;
    logic       ram_wr_done;
    logic       busy;
    logic       err_multi;

    int asserts_done;
    int fails;

    // Reference model: one access is described by its start edge, channel and
    // wait count; everything expected is derived from the offset to that edge.
    int         cyc;
    bit         m_active;
    int         m_s;
    int         m_ch;
    int         m_w;
    logic [7:0] m_rom_addr;
    logic [7:0] m_ram_addr;
    logic [7:0] m_wdata;
    logic [7:0] m_rom_rd;
    logic [7:0] m_ram_rd;
    bit         m_err;

    mem_access_ctrl #(
        .ADDR_W   (8),
        .DATA_W   (8),
        .ROM_WAIT (ROM_W),
        .RAM_WAIT (RAM_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rom_garant    (rom_garant),
        .ram_garant_rd (ram_garant_rd),
        .ram_garant_wr (ram_garant_wr),
        .rom_addr      (rom_addr),
        .ram_addr      (ram_addr),
        .ram_wdata     (ram_wdata),
        .mem_rom_en    (mem_rom_en),
        .mem_rom_addr  (mem_rom_addr),
        .mem_rom_rdata (mem_rom_rdata),
        .mem_ram_en    (mem_ram_en),
        .mem_ram_we    (mem_ram_we),
        .mem_ram_addr  (mem_ram_addr),
        .mem_ram_wdata (mem_ram_wdata),
        .mem_ram_rdata (mem_ram_rdata),
        .rom_rdata     (rom_rdata),
        .ram_rdata     (ram_rdata),
        .rom_done      (rom_done),
        .ram_rd_done   (ram_rd_done),
        .ram_wr_done   (ram_wr_done),
        .busy          (busy),
        .err_multi     (err_multi)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic grant_of(input int ch);
        case (ch)
            0:       return rom_garant;
            1:       return ram_garant_rd;
            default: return ram_garant_wr;
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_edge();
        int pk;
        cyc++;
        if (reset) begin
            m_active = 1'b0;
            m_rom_rd = 8'h00;
            m_ram_rd = 8'h00;
            m_err    = 1'b0;
        end else if (m_active) begin
            pk = cyc - 1 - m_s;
            if (pk == m_w) begin
                if (m_ch == 0) m_rom_rd = mem_rom_rdata;
                else if (m_ch == 1) m_ram_rd = mem_ram_rdata;
            end
            if ((pk >= m_w + 1) && !grant_of(m_ch)) m_active = 1'b0;
        end else if (rom_garant || ram_garant_rd || ram_garant_wr) begin
            m_active = 1'b1;
            m_s      = cyc;
            m_ch     = rom_garant ? 0 : (ram_garant_rd ? 1 : 2);
            m_w      = (m_ch == 0) ? ROM_W : RAM_W;
            if (m_ch == 0) m_rom_addr = rom_addr;
            else m_ram_addr = ram_addr;
            if (m_ch == 2) m_wdata = ram_wdata;
            if (int'(rom_garant) + int'(ram_garant_rd) + int'(ram_garant_wr) > 1) m_err = 1'b1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        asserts_done++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, observed, expected);
        end
    endtask

    // Compare every output against the model for the current cycle.
    task automatic compare_all();
        int k;
        bit acc;
        k   = cyc - m_s;
        acc = m_active && (k <= m_w);
        checkOutput("rom_en", 32'(mem_rom_en), 32'(acc && m_ch == 0));
        checkOutput("ram_en", 32'(mem_ram_en), 32'(acc && m_ch != 0));
        checkOutput("ram_we", 32'(mem_ram_we), 32'(acc && m_ch == 2 && k == m_w));
        checkOutput("rom_done", 32'(rom_done), 32'(m_active && m_ch == 0 && k == m_w + 1));
        checkOutput("ram_rd_done", 32'(ram_rd_done), 32'(m_active && m_ch == 1 && k == m_w + 1));
        checkOutput("ram_wr_done", 32'(ram_wr_done), 32'(m_active && m_ch == 2 && k == m_w + 1));
        checkOutput("busy", 32'(busy), 32'(m_active));
        checkOutput("err_multi", 32'(err_multi), 32'(m_err));
        checkOutput("rom_rdata", 32'(rom_rdata), 32'(m_rom_rd));
        checkOutput("ram_rdata", 32'(ram_rdata), 32'(m_ram_rd));
        if (acc && m_ch == 0) checkOutput("rom_addr", 32'(mem_rom_addr), 32'(m_rom_addr));
        if (acc && m_ch != 0) checkOutput("ram_addr", 32'(mem_ram_addr), 32'(m_ram_addr));
        if (acc && m_ch == 2 && k == m_w) checkOutput("ram_wdata", 32'(mem_ram_wdata), 32'(m_wdata));
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            compare_all();
        end
    endtask

    task automatic applyStimulus(input logic g_rom, input logic g_rd, input logic g_wr, input int n);
        rom_garant    = g_rom;
        ram_garant_rd = g_rd;
        ram_garant_wr = g_wr;
        tick(n);
    endtask

    initial begin
        asserts_done  = 0;
        fails         = 0;
        cyc           = 0;
        m_active      = 1'b0;
        m_s           = 0;
        m_ch          = 0;
        m_w           = 0;
        m_rom_addr    = 8'h00;
        m_ram_addr    = 8'h00;
        m_wdata       = 8'h00;
        m_rom_rd      = 8'h00;
        m_ram_rd      = 8'h00;
        m_err         = 1'b0;
        reset         = 1'b1;
        rom_garant    = 1'b0;
        ram_garant_rd = 1'b0;
        ram_garant_wr = 1'b0;
        rom_addr      = 8'h00;
        ram_addr      = 8'h00;
        ram_wdata     = 8'h00;
        mem_rom_rdata = 8'h00;
        mem_ram_rdata = 8'h00;

        $display("[TB] reset");
        tick(2);
        reset = 1'b0;
        tick(1);

        $display("[TB] single ROM read");
        rom_addr      = 8'h3C;
        mem_rom_rdata = 8'hA5;
        applyStimulus(1'b1, 1'b0, 1'b0, 3);
        checkOutput("t1_done", 32'(rom_done), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 2);
        checkOutput("t1_rdata", 32'(rom_rdata), 32'hA5);

        $display("[TB] RAM write with long-held grant");
        ram_addr  = 8'h10;
        ram_wdata = 8'h5A;
        applyStimulus(1'b0, 1'b0, 1'b1, RAM_W + 7);
        applyStimulus(1'b0, 1'b0, 1'b0, 2);

        $display("[TB] simultaneous ROM and RAM-read grants");
        rom_addr      = 8'h44;
        ram_addr      = 8'h55;
        mem_rom_rdata = 8'h4B;
        mem_ram_rdata = 8'h5C;
        applyStimulus(1'b1, 1'b1, 1'b0, 4);
        applyStimulus(1'b0, 1'b1, 1'b0, 6);
        applyStimulus(1'b0, 1'b0, 1'b0, 2);
        checkOutput("t3_err", 32'(err_multi), 32'd1);
        checkOutput("t3_ram_rdata", 32'(ram_rdata), 32'h5C);

        $display("[TB] grant dropped during RAM read");
        ram_addr      = 8'h77;
        mem_ram_rdata = 8'h9E;
        applyStimulus(1'b0, 1'b1, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 5);

        $display("[TB] reset in second access cycle");
        ram_addr      = 8'h21;
        mem_ram_rdata = 8'h3D;
        applyStimulus(1'b0, 1'b1, 1'b0, 2);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1);
        reset = 1'b0;
        checkOutput("t5_busy", 32'(busy), 32'd0);
        checkOutput("t5_err_cleared", 32'(err_multi), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 5);
        applyStimulus(1'b0, 1'b0, 1'b0, 2);
        checkOutput("t5_ram_rdata", 32'(ram_rdata), 32'h3D);

        $display("[TB] back-to-back ROM reads");
        for (int i = 1; i <= 3; i++) begin
            rom_addr      = 8'(i);
            mem_rom_rdata = 8'hC0 + 8'(i);
            applyStimulus(1'b1, 1'b0, 1'b0, 3);
            applyStimulus(1'b0, 1'b0, 1'b0, 1);
            checkOutput("t6_rdata", 32'(rom_rdata), 32'hC0 + 32'(i));
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 2);

        $display("[TB] random traffic");
        for (int n = 0; n < 500; n++) begin
            reset         = ($urandom_range(0, 99) == 0);
            rom_addr      = 8'($urandom);
            ram_addr      = 8'($urandom);
            ram_wdata     = 8'($urandom);
            mem_rom_rdata = 8'($urandom);
            mem_ram_rdata = 8'($urandom);
            applyStimulus(($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 30),
                          ($urandom_range(0, 99) < 30), 1);
        end
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts_done, fails);
        $finish;
    end

endmodule
